uart_rx_fifo: RTL

//  Parametrised UART receiver for the SoC peripheral bus. Generalises the fixed 8N1 receiver:

---
 rtl/uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime framing config, 3-sample majority voting,
// a valid/ready drained receive FIFO and sticky parity/frame/overrun flags.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              rx_i,
  input  logic [DIV_W-1:0]                  cfg_div_i,
  input  logic [1:0]                        cfg_bits_i,
  input  logic                              cfg_parity_en_i,
  input  logic                              cfg_parity_odd_i,
  input  logic                              cfg_stop2_i,
  output logic [7:0]                        rx_data_o,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              busy_o,
  output logic                              err_parity_o,
  output logic                              err_frame_o,
  output logic                              err_overrun_o,
  input  logic                              err_clr_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e             state_q, state_d;
  logic               rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               stop_2nd_q, stop_2nd_d;
  logic [1:0]         smp_q, smp_d;
  logic [7:0]         shift_q, shift_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         bits_q, bits_d;
  logic               par_en_q, par_en_d;
  logic               par_odd_q, par_odd_d;
  logic               stop2_q, stop2_d;
  logic               busy_q;
  logic               err_par_q, err_frm_q, err_ovr_q;

  logic tick_c, vote_tick_c, end_tick_c, vote_c;
  logic push_c, set_par_c, set_frm_c;

  assign tick_c      = (state_q != ST_IDLE) && (tick_cnt_q == div_q);
  assign vote_tick_c = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE / 2 + 1));
  assign end_tick_c  = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign vote_c      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);

  // Receiver next-state: timing counters, sampling and frame sequencing
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_2nd_d = stop_2nd_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    push_c     = 1'b0;
    set_par_c  = 1'b0;
    set_frm_c  = 1'b0;

    if (state_q != ST_IDLE) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + DIV_W'(1);
    end
    if (tick_c) begin
      os_cnt_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OS_W'(1);
      if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) smp_d[0] = rx_s2_q;
      if (os_cnt_q == OS_W'(OVERSAMPLE / 2))     smp_d[1] = rx_s2_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d    = ST_START;
          os_cnt_d   = '0;
          bit_idx_d  = '0;
          stop_2nd_d = 1'b0;
          shift_d    = '0;
          div_d      = cfg_div_i;
          bits_d     = cfg_bits_i;
          par_en_d   = cfg_parity_en_i;
          par_odd_d  = cfg_parity_odd_i;
          stop2_d    = cfg_stop2_i;
        end
      end
      ST_START: begin
        if (vote_tick_c && vote_c) begin
          state_d = ST_IDLE;
        end else if (end_tick_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (vote_tick_c) shift_d[bit_idx_q] = vote_c;
        if (end_tick_c) begin
          if (bit_idx_q == {1'b0, bits_q} + 3'd4) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (vote_tick_c) set_par_c = ((^shift_q) ^ vote_c) != par_odd_q;
        if (end_tick_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Last stop bit completes the frame at its vote so the next start edge is not missed
        if (vote_tick_c) begin
          set_frm_c = !vote_c;
          if (!stop2_q || stop_2nd_q) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (end_tick_c && stop2_q && !stop_2nd_q) stop_2nd_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      stop_2nd_q <= 1'b0;
      smp_q      <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      bits_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_2nd_q <= stop_2nd_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt_c;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic [7:0]       head_q, head_d;
  logic             pop_c, full_c, wr_en_c, overrun_c;

  assign pop_c     = valid_q & rx_ready_i;
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en_c   = push_c & (~full_c | pop_c);
  assign overrun_c = push_c & full_c & ~pop_c;
  assign rd_nxt_c  = rd_ptr_q + PTR_W'(1);

  // Registered head tracks what the FIFO head will be after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    if (wr_en_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);

    head_d = head_q;
    if (pop_c) begin
      if (count_q > CNT_W'(1)) head_d = mem_q[rd_nxt_c];
      else if (wr_en_c)        head_d = shift_q;
      else                     head_d = '0;
    end else if (count_q == '0 && wr_en_c) begin
      head_d = shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_nxt_c;
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
      head_q    <= head_d;
      err_par_q <= set_par_c | (err_par_q & ~err_clr_i);
      err_frm_q <= set_frm_c | (err_frm_q & ~err_clr_i);
      err_ovr_q <= overrun_c | (err_ovr_q & ~err_clr_i);
    end
  end

  assign rx_data_o     = head_q;
  assign rx_valid_o    = valid_q;
  assign fifo_count_o  = count_q;
  assign busy_o        = busy_q;
  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_overrun_o = err_ovr_q;

endmodule
